// File: rtl/dmux_delay_line_if.sv
// rtl/dmux_delay_line_if.sv - input stream and routed outputs of dmux_delay_line
interface dmux_delay_line_if #(
    parameter int WIDTH = 1,
    parameter int CW    = 5
);
    logic             en;
    logic             flush;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             sel_in;
    logic [WIDTH-1:0] dout_0;
    logic             valid_0;
    logic [WIDTH-1:0] dout_1;
    logic             valid_1;
    logic [CW-1:0]    inflight;

    modport master (
        output en, flush, din, din_valid, sel_in,
        input  dout_0, valid_0, dout_1, valid_1, inflight
    );

    modport slave (
        input  en, flush, din, din_valid, sel_in,
        output dout_0, valid_0, dout_1, valid_1, inflight
    );
endinterface

// File: rtl/dmux_delay_line.sv
// rtl/dmux_delay_line.sv - fixed-latency 1-to-2 routing delay line; option DMUX_ZERO_IDLE_EN
module dmux_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    parameter int CW    = 5
) (
    input logic              clk,
    input logic              rst,
    dmux_delay_line_if.slave bus
);
    localparam int NS = (DEPTH > 1) ? DEPTH - 1 : 1;

    logic             advance;
    logic             accept;
    logic             emit;
    logic             last_v;
    logic             last_sel;
    logic [WIDTH-1:0] last_data;

    assign advance = bus.en & ~bus.flush;
    assign accept  = advance & bus.din_valid;
    assign emit    = advance & last_v;

    generate
        if (DEPTH > 1) begin : g_stages
            logic [NS-1:0]    s_v;
            logic [NS-1:0]    s_sel;
            logic [WIDTH-1:0] s_data [NS];

            always_ff @(posedge clk) begin
                if (rst || bus.flush) begin
                    s_v <= '0;
                end else if (bus.en) begin
                    s_v[0] <= bus.din_valid;
                    for (int i = 1; i < NS; i++) begin
                        s_v[i] <= s_v[i-1];
                    end
                end
            end

            // sel is masked by din_valid so an undriven tag on an idle cycle never enters the pipe
            always_ff @(posedge clk) begin
                if (advance) begin
                    s_sel[0]  <= bus.din_valid & bus.sel_in;
                    s_data[0] <= bus.din;
                    for (int i = 1; i < NS; i++) begin
                        s_sel[i]  <= s_sel[i-1];
                        s_data[i] <= s_data[i-1];
                    end
                end
            end

            assign last_v    = s_v[NS-1];
            assign last_sel  = s_sel[NS-1];
            assign last_data = s_data[NS-1];
        end else begin : g_direct
            assign last_v    = bus.din_valid;
            assign last_sel  = bus.din_valid & bus.sel_in;
            assign last_data = bus.din;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dout_0  <= '0;
            bus.dout_1  <= '0;
            bus.valid_0 <= 1'b0;
            bus.valid_1 <= 1'b0;
        end else begin
            bus.valid_0 <= emit & ~last_sel;
            bus.valid_1 <= emit & last_sel;
            if (emit && !last_sel) begin
                bus.dout_0 <= last_data;
            end
`ifdef DMUX_ZERO_IDLE_EN
            else begin
                bus.dout_0 <= '0;
            end
`endif
            if (emit && last_sel) begin
                bus.dout_1 <= last_data;
            end
`ifdef DMUX_ZERO_IDLE_EN
            else begin
                bus.dout_1 <= '0;
            end
`endif
        end
    end

    // With DEPTH=1 accept and emit always coincide, so the count stays at zero
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            bus.inflight <= '0;
        end else if (accept && !emit) begin
            bus.inflight <= bus.inflight + CW'(1);
        end else if (emit && !accept) begin
            bus.inflight <= bus.inflight - CW'(1);
        end
    end
endmodule

// File: doc/dmux_delay_line.md
Name: dmux_delay_line

Overview:
- 1-to-2 routing delay line: the counterpart of our 2-to-1 select-and-delay flop.
- Accepts one input stream tagged with a select bit, delays it by DEPTH enabled clock cycles, and drives it onto output 0 or output 1 with a one-cycle valid strobe.
- Used wherever a single datapath result fans back out to one of two consumers with fixed, matched latency.

Parameters:
- WIDTH, 1: data width in bits.
- DEPTH, 4: latency in enabled clock edges; legal range 1..16.
- CW, 5: in-flight counter width; must satisfy 2^CW > DEPTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  pipeline advance enable; 0 = stall, all state frozen except valid strobes.
- flush  input  1  discard every in-flight item.
- din  input  WIDTH  input data.
- din_valid  input  1  din carries an item this cycle.
- sel_in  input  1  route tag: 0 -> output 0, 1 -> output 1.
- dout_0  output  WIDTH  data for consumer 0.
- valid_0  output  1  one-cycle strobe: dout_0 updated this cycle.
- dout_1  output  WIDTH  data for consumer 1.
- valid_1  output  1  one-cycle strobe: dout_1 updated this cycle.
- inflight  output  CW  count of accepted items not yet emitted.

Behaviour:
- Clock and reset: reset is rst, synchronous, active-high; clock is clk.
- Reset values:
  - dout_0 = 0, dout_1 = 0, valid_0 = 0, valid_1 = 0, inflight = 0.
  - All internal stage valid bits = 0. Stage data need not be reset.
- Structure:
  - Internal stages s[0..DEPTH-2] each hold {v, sel, data}, followed by the output registers.
  - For DEPTH=1 there are no internal stages; the output registers load directly from din/sel_in/din_valid.
- Accept: an item is accepted at an edge where en=1, din_valid=1, flush=0. It is loaded into s[0], or into the outputs when DEPTH=1.
- Advance: on each edge with en=1 and flush=0, every stage shifts one place.
- Emission: the item leaving the last stage (or din when DEPTH=1) with v=1 loads dout_{sel} and pulses valid_{sel} for exactly one cycle.
  - The other output keeps its previous value and its valid is 0.
  - Items with v=0 leave both douts unchanged and both valids 0.
- Latency: an item accepted at edge N appears at edge N+DEPTH-1 when en stays high, i.e. valid is high in the cycle following that edge. Each en=0 edge adds one cycle.
- Stall (en=0): stages and douts hold; valid_0 and valid_1 are forced to 0 on that edge; din is ignored. No strobe ever repeats.
- Flush (flush=1 at an edge, en ignored):
  - All stage v bits are cleared; din that cycle is dropped; valid_0 = valid_1 = 0; douts hold; inflight = 0.
  - flush takes precedence over en and din_valid.
- inflight:
  - Registered; +1 on accept, -1 on emission, unchanged when both or neither occur in one edge.
  - Cleared by flush or rst.
  - For DEPTH=1 it is always 0.
  - Never exceeds DEPTH-1.
- Back-to-back: one item per cycle with any mix of sel values; consecutive items to the same output produce consecutive valid strobes.
- Reset mid-operation: all in-flight items are lost, no strobe occurs after the reset edge, outputs return to reset values.
- sel_in is sampled only with an accepted item. X on sel_in while din_valid=0 must not propagate.

Optional Feature:
- Macro: DMUX_ZERO_IDLE_EN.
- Defined: on any edge where valid_k is 0 after the update (stall, flush, bubble, or item routed to the other output), dout_k is cleared to 0. Data is therefore nonzero only while its strobe is high.
- Undefined: douts hold their last emitted value as described above.
- Reset values and all strobe timing are identical in both builds.

Test Plan:
- Reset then single item, DEPTH=4: din=1, sel_in=1, din_valid=1 at edge 1 -> valid_1 high in the cycle after edge 4, dout_1=1; valid_0 never high; inflight goes 1 through edge 3, then 0.
- Alternating stream, DEPTH=4: 8 consecutive items with sel 0,1,0,1,... and data 1,0,1,1,0,0,1,0 -> strobes alternate valid_0/valid_1 each cycle with matching data; inflight saturates at 3.
- Stall: en=0 for 2 cycles while 2 items are in flight -> no strobes during the stall; items emerge 2 cycles late, in order; inflight is unchanged during the stall.
- Flush with simultaneous din_valid=1 and 3 items in flight -> no strobes afterwards; inflight=0 next cycle; dout values are held, or 0 with DMUX_ZERO_IDLE_EN.
- DEPTH=1 build: din_valid=1, sel_in=0, din=1 at edge N -> valid_0=1 and dout_0=1 after edge N; inflight stays 0.
- rst asserted mid-stream with 3 items in flight -> all outputs 0 after the reset edge; no strobe for any pre-reset item.
